// File: rtl/decode_pkg.sv
// decode_pkg: opcode/funct constants, ALU control encodings and the decoded bundle type
package decode_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_DIV = 6'b011010;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_MUL = 4'b0011,
    ALU_DIV = 4'b0100,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_ctr_e;
  // Only the raw 16-bit field is stored; widening to XLEN happens at the stage output
  localparam int IMM_W = 16;
  typedef logic [IMM_W-1:0] imm_t;
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [4:0] shamt;
    alu_ctr_e   alu_ctr;
    imm_t       imm;
    logic       sext;
    logic       alu_imm;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       illegal;
  } bundle_t;
endpackage

// File: rtl/decode_logic.sv
// decode_logic: purely combinational instruction word to decoded bundle map
module decode_logic
  import decode_pkg::*;
#(
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic [31:0] i_inst,
  output bundle_t     o_bundle
);
  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_wr;
  assign w_op = i_inst[31:26];
  assign w_fn = i_inst[5:0];
  always_comb begin
    o_bundle       = '0;
    o_bundle.rs    = i_inst[25:21];
    o_bundle.rt    = i_inst[20:16];
    o_bundle.dst   = i_inst[20:16];
    o_bundle.shamt = i_inst[10:6];
    o_bundle.imm   = i_inst[15:0];
    o_bundle.sext  = 1'b1;
    w_wr           = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        o_bundle.dst = i_inst[15:11];
        case (w_fn)
          FN_ADD:  o_bundle.alu_ctr = ALU_ADD;
          FN_SUB:  o_bundle.alu_ctr = ALU_SUB;
          FN_AND:  o_bundle.alu_ctr = ALU_AND;
          FN_OR:   o_bundle.alu_ctr = ALU_OR;
          FN_SLT:  o_bundle.alu_ctr = ALU_SLT;
          FN_MUL:  if (MULDIV_EN) o_bundle.alu_ctr = ALU_MUL; else o_bundle.illegal = 1'b1;
          FN_DIV:  if (MULDIV_EN) o_bundle.alu_ctr = ALU_DIV; else o_bundle.illegal = 1'b1;
          default: o_bundle.illegal = 1'b1;
        endcase
        w_wr = !o_bundle.illegal;
      end
      OP_LW: begin
        o_bundle.alu_ctr = ALU_ADD;
        o_bundle.alu_imm = 1'b1;
        o_bundle.mem_rd  = 1'b1;
        w_wr             = 1'b1;
      end
      OP_SW: begin
        o_bundle.alu_ctr = ALU_ADD;
        o_bundle.alu_imm = 1'b1;
        o_bundle.mem_wr  = 1'b1;
      end
      OP_BEQ: begin
        o_bundle.alu_ctr = ALU_SUB;
        o_bundle.branch  = 1'b1;
      end
      OP_ADDI: begin
        o_bundle.alu_ctr = ALU_ADD;
        o_bundle.alu_imm = 1'b1;
        w_wr             = 1'b1;
      end
      OP_ANDI: begin
        o_bundle.alu_ctr = ALU_AND;
        o_bundle.alu_imm = 1'b1;
        o_bundle.sext    = 1'b0;
        w_wr             = 1'b1;
      end
      OP_ORI: begin
        o_bundle.alu_ctr = ALU_OR;
        o_bundle.alu_imm = 1'b1;
        o_bundle.sext    = 1'b0;
        w_wr             = 1'b1;
      end
      default: o_bundle.illegal = 1'b1;
    endcase
    // Writes to $0 are architecturally discarded
    o_bundle.reg_wr = w_wr && (o_bundle.dst != 5'd0);
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with a 2-entry skid buffer, valid/ready flow control and flush
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            inValid,
  output logic            inReady,
  input  logic [31:0]     inst,
  output logic            outValid,
  input  logic            outReady,
  output logic [4:0]      outRs,
  output logic [4:0]      outRt,
  output logic [4:0]      outDst,
  output logic [4:0]      outShamt,
  output logic [3:0]      outAluCtr,
  output logic            outAluImm,
  output logic [XLEN-1:0] outImm,
  output logic            outRegWr,
  output logic            outMemRd,
  output logic            outMemWr,
  output logic            outBranch,
  output logic            outIllegal
);
  bundle_t w_dec;
  bundle_t r_main;
  bundle_t r_skid;
  logic    r_main_valid;
  logic    r_skid_valid;
  logic    w_in_fire;
  logic    w_load;
  decode_logic #(.MULDIV_EN(MULDIV_EN)) u_decode_logic (
    .i_inst  (inst),
    .o_bundle(w_dec)
  );
  assign inReady   = !r_skid_valid;
  assign w_in_fire = inValid && inReady;
  // Main slot may be (re)loaded when it is empty or its contents leave this edge
  assign w_load    = !r_main_valid || outReady;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_load) begin
      r_main_valid <= r_skid_valid || w_in_fire;
      r_skid_valid <= 1'b0;
      if (r_skid_valid) r_main <= r_skid;
      else if (w_in_fire) r_main <= w_dec;
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end
  assign outValid   = r_main_valid;
  assign outRs      = r_main.rs;
  assign outRt      = r_main.rt;
  assign outDst     = r_main.dst;
  assign outShamt   = r_main.shamt;
  assign outAluCtr  = r_main.alu_ctr;
  assign outAluImm  = r_main.alu_imm;
  assign outImm     = {{(XLEN-IMM_W){r_main.sext & r_main.imm[IMM_W-1]}}, r_main.imm};
  assign outRegWr   = r_main.reg_wr;
  assign outMemRd   = r_main.mem_rd;
  assign outMemWr   = r_main.mem_wr;
  assign outBranch  = r_main.branch;
  assign outIllegal = r_main.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized traffic against a queue-based reference model
module tb_decode_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, inValid = 1'b0, outReady = 1'b0;
  logic [31:0] inst = 32'h0;
  logic inReady, outValid, outAluImm, outRegWr, outMemRd, outMemWr, outBranch, outIllegal;
  logic [4:0] outRs, outRt, outDst, outShamt;
  logic [3:0] outAluCtr;
  logic [31:0] outImm;
  logic z_inReady, z_outValid, z_outAluImm, z_outRegWr, z_outMemRd, z_outMemWr, z_outBranch, z_outIllegal;
  logic [4:0] z_outRs, z_outRt, z_outDst, z_outShamt;
  logic [3:0] z_outAluCtr;
  logic [31:0] z_outImm;
  int n_cmp = 0, n_err = 0;

  typedef struct packed {
    logic [4:0] rs, rt, dst, shamt;
    logic [3:0] alu;
    logic [31:0] imm;
    logic alu_imm, reg_wr, mem_rd, mem_wr, branch, illegal;
  } exp_t;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .inValid(inValid), .inReady(inReady), .inst(inst),
    .outValid(outValid), .outReady(outReady), .outRs(outRs), .outRt(outRt), .outDst(outDst),
    .outShamt(outShamt), .outAluCtr(outAluCtr), .outAluImm(outAluImm), .outImm(outImm),
    .outRegWr(outRegWr), .outMemRd(outMemRd), .outMemWr(outMemWr), .outBranch(outBranch),
    .outIllegal(outIllegal)
  );

  decode_stage #(.XLEN(32), .MULDIV_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .inValid(inValid), .inReady(z_inReady), .inst(inst),
    .outValid(z_outValid), .outReady(outReady), .outRs(z_outRs), .outRt(z_outRt), .outDst(z_outDst),
    .outShamt(z_outShamt), .outAluCtr(z_outAluCtr), .outAluImm(z_outAluImm), .outImm(z_outImm),
    .outRegWr(z_outRegWr), .outMemRd(z_outMemRd), .outMemWr(z_outMemWr), .outBranch(z_outBranch),
    .outIllegal(z_outIllegal)
  );

  // Expected decode straight from the instruction-set table
  function automatic exp_t ref_dec(logic [31:0] w, bit md);
    exp_t e = '0;
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    bit wr = 1'b0;
    e.rs = w[25:21];
    e.rt = w[20:16];
    e.shamt = w[10:6];
    e.dst = (op == 6'd0) ? w[15:11] : w[20:16];
    e.imm = (op == 6'd12 || op == 6'd13) ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
    if (op == 6'd0) begin
      if (fn == 6'd32) e.alu = 4'd2;
      else if (fn == 6'd34) e.alu = 4'd6;
      else if (fn == 6'd36) e.alu = 4'd0;
      else if (fn == 6'd37) e.alu = 4'd1;
      else if (fn == 6'd42) e.alu = 4'd7;
      else if (md && fn == 6'd24) e.alu = 4'd3;
      else if (md && fn == 6'd26) e.alu = 4'd4;
      else e.illegal = 1'b1;
      wr = !e.illegal;
    end else if (op == 6'd35) begin e.alu = 4'd2; e.alu_imm = 1'b1; e.mem_rd = 1'b1; wr = 1'b1; end
    else if (op == 6'd43) begin e.alu = 4'd2; e.alu_imm = 1'b1; e.mem_wr = 1'b1; end
    else if (op == 6'd4)  begin e.alu = 4'd6; e.branch = 1'b1; end
    else if (op == 6'd8)  begin e.alu = 4'd2; e.alu_imm = 1'b1; wr = 1'b1; end
    else if (op == 6'd12) begin e.alu = 4'd0; e.alu_imm = 1'b1; wr = 1'b1; end
    else if (op == 6'd13) begin e.alu = 4'd1; e.alu_imm = 1'b1; wr = 1'b1; end
    else e.illegal = 1'b1;
    e.reg_wr = wr && (e.dst != 5'd0);
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o = {outRs, outRt, outDst, outShamt, outAluCtr, outImm,
         outAluImm, outRegWr, outMemRd, outMemWr, outBranch, outIllegal};
    return o;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    logic [5:0] ops [8] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd12, 6'd13, 6'd15};
    logic [5:0] fns [8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd24, 6'd26, 6'd1};
    w[31:26] = ops[$urandom_range(0, 7)];
    if (w[31:26] == 6'd0) w[5:0] = fns[$urandom_range(0, 7)];
    if ($urandom_range(0, 5) == 0) w[20:16] = 5'd0;
    if ($urandom_range(0, 5) == 0) w[15:11] = 5'd0;
    return w;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (outValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", outValid); end
    n_cmp++; if (inReady !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", inReady); end
    n_cmp++; if (obs() !== '0) begin n_err++; $display("FAIL reset_fields: got %h want 0", obs()); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    outReady = 1'b1; inValid = 1'b1; inst = 32'h00221820;
    @(posedge clk); #1;
    inValid = 1'b0;
    n_cmp++; if (outValid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", outValid); end
    n_cmp++; if ({outAluCtr, outDst, outRegWr, outAluImm} !== {4'b0010, 5'd3, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL add_fields: got %h want %h", {outAluCtr, outDst, outRegWr, outAluImm}, {4'b0010, 5'd3, 1'b1, 1'b0}); end
    @(posedge clk); #1;
    n_cmp++; if (outValid !== 1'b0) begin n_err++; $display("FAIL add_drained: got %b want 0", outValid); end
  endtask

  task automatic test_imm();
    outReady = 1'b1; inValid = 1'b1; inst = 32'h3405FFFF;
    @(posedge clk); #1;
    inst = 32'h8C24FFFC;
    n_cmp++; if ({outImm, outAluCtr, outDst} !== {32'h0000FFFF, 4'b0001, 5'd5}) begin
      n_err++; $display("FAIL ori_fields: got %h want %h", {outImm, outAluCtr, outDst}, {32'h0000FFFF, 4'b0001, 5'd5}); end
    @(posedge clk); #1;
    inValid = 1'b0;
    n_cmp++; if ({outValid, outImm, outMemRd, outDst} !== {1'b1, 32'hFFFFFFFC, 1'b1, 5'd4}) begin
      n_err++; $display("FAIL lw_fields: got %h want %h", {outValid, outImm, outMemRd, outDst}, {1'b1, 32'hFFFFFFFC, 1'b1, 5'd4}); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] a = 32'h00221820, b = 32'h3405FFFF, c = 32'h8C24FFFC;
    outReady = 1'b0; inValid = 1'b1; inst = a;
    @(posedge clk); #1;
    n_cmp++; if ({outValid, inReady} !== 2'b11) begin n_err++; $display("FAIL bp_one: got %b want 11", {outValid, inReady}); end
    inst = b;
    @(posedge clk); #1;
    n_cmp++; if (inReady !== 1'b0) begin n_err++; $display("FAIL bp_two_ready: got %b want 0", inReady); end
    n_cmp++; if (obs() !== ref_dec(a, 1)) begin n_err++; $display("FAIL bp_hold_a: got %h want %h", obs(), ref_dec(a, 1)); end
    inst = c;
    @(posedge clk); #1;
    n_cmp++; if ({outValid, inReady} !== 2'b10) begin n_err++; $display("FAIL bp_stall: got %b want 10", {outValid, inReady}); end
    n_cmp++; if (obs() !== ref_dec(a, 1)) begin n_err++; $display("FAIL bp_stable_a: got %h want %h", obs(), ref_dec(a, 1)); end
    outReady = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (obs() !== ref_dec(b, 1)) begin n_err++; $display("FAIL bp_drain_b: got %h want %h", obs(), ref_dec(b, 1)); end
    @(posedge clk); #1;
    inValid = 1'b0;
    n_cmp++; if ({outValid, obs()} !== {1'b1, ref_dec(c, 1)}) begin n_err++; $display("FAIL bp_drain_c: got %h want %h", obs(), ref_dec(c, 1)); end
    @(posedge clk); #1;
    n_cmp++; if (outValid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", outValid); end
  endtask

  task automatic test_flush();
    outReady = 1'b0; inValid = 1'b1; inst = 32'h00221820;
    @(posedge clk); #1;
    inst = 32'h3405FFFF;
    @(posedge clk); #1;
    inst = 32'h8C24FFFC; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; inValid = 1'b0;
    n_cmp++; if ({outValid, inReady} !== 2'b01) begin n_err++; $display("FAIL flush_state: got %b want 01", {outValid, inReady}); end
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (outValid !== 1'b0) begin n_err++; $display("FAIL flush_leak%0d: got %b want 0", i, outValid); end
    end
  endtask

  task automatic test_illegal();
    outReady = 1'b1; inValid = 1'b1; inst = 32'h3C011234;
    @(posedge clk); #1;
    inst = 32'h00221818;
    n_cmp++; if ({outIllegal, outRegWr, outMemRd, outMemWr, outBranch, outAluImm, outAluCtr} !== {6'b100000, 4'd0}) begin
      n_err++; $display("FAIL lui_illegal: got %b want 1000000000", {outIllegal, outRegWr, outMemRd, outMemWr, outBranch, outAluImm, outAluCtr}); end
    @(posedge clk); #1;
    inst = 32'h20000005;
    n_cmp++; if ({outIllegal, outAluCtr, outRegWr} !== {1'b0, 4'b0011, 1'b1}) begin
      n_err++; $display("FAIL mul_en: got %b want 000111", {outIllegal, outAluCtr, outRegWr}); end
    n_cmp++; if ({z_outIllegal, z_outAluCtr, z_outRegWr} !== {1'b1, 4'b0000, 1'b0}) begin
      n_err++; $display("FAIL mul_dis: got %b want 100000", {z_outIllegal, z_outAluCtr, z_outRegWr}); end
    @(posedge clk); #1;
    inValid = 1'b0;
    n_cmp++; if ({outValid, outIllegal, outAluImm, outRegWr} !== 4'b1010) begin
      n_err++; $display("FAIL addi_r0: got %b want 1010", {outValid, outIllegal, outAluImm, outRegWr}); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    outReady = 1'b0; inValid = 1'b1; inst = 32'h00221820;
    repeat (2) @(posedge clk);
    #3;
    inValid = 1'b0; rst_n = 1'b0;
    #1;
    n_cmp++; if ({outValid, inReady, z_inReady} !== 3'b011) begin n_err++; $display("FAIL arst_ctrl: got %b want 011", {outValid, inReady, z_inReady}); end
    n_cmp++; if (obs() !== '0) begin n_err++; $display("FAIL arst_fields: got %h want 0", obs()); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b1; inValid = 1'b1; inst = 32'h8C24FFFC;
    @(posedge clk); #1;
    inValid = 1'b0;
    n_cmp++; if ({outValid, obs()} !== {1'b1, ref_dec(32'h8C24FFFC, 1)}) begin
      n_err++; $display("FAIL arst_after: got %h want %h", obs(), ref_dec(32'h8C24FFFC, 1)); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    for (int i = 0; i < 500; i++) begin
      inValid = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 29) == 0);
      inst = rand_inst();
      @(posedge clk);
      begin
        bit pop, push;
        pop = (q.size() > 0) && outReady;
        push = inValid && (q.size() < 2);
        if (flush) q.delete();
        else begin
          if (pop) void'(q.pop_front());
          if (push) q.push_back(inst);
        end
      end
      #1;
      n_cmp++; if ({outValid, inReady} !== {q.size() > 0, q.size() < 2}) begin
        n_err++; $display("FAIL rnd_hs[%0d]: got %b want %b", i, {outValid, inReady}, {q.size() > 0, q.size() < 2}); end
      if (q.size() > 0) begin
        n_cmp++; if (obs() !== ref_dec(q[0], 1)) begin
          n_err++; $display("FAIL rnd_dec[%0d]: got %h want %h inst %h", i, obs(), ref_dec(q[0], 1), q[0]); end
        n_cmp++; if ({z_outIllegal, z_outAluCtr} !== {ref_dec(q[0], 0).illegal, ref_dec(q[0], 0).alu}) begin
          n_err++; $display("FAIL rnd_nomd[%0d]: got %h want %h inst %h", i, {z_outIllegal, z_outAluCtr}, {ref_dec(q[0], 0).illegal, ref_dec(q[0], 0).alu}, q[0]); end
      end
    end
    flush = 1'b0; inValid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_backpressure();
    test_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
